// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - 8-way set lookup/refill controller with per-set round-robin victim selection
// Optional saturating hit/miss counters are built when CACHE_CTRL_STATS_EN is defined.
module cache_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int SET_BITS    = 3,
  parameter int OFFSET_BITS = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     req_ready,
  output logic                     resp_valid,
  output logic                     resp_hit,
  output logic [255:0]             resp_data,
  output logic [(1<<SET_BITS)-1:0] set_out,
  output logic                     hit,
  output logic                     mem_write,
  output logic [7:0]               way_sel,
  output logic                     viv_out,
  output logic [23:0]              tag_out,
  output logic [255:0]             line_out,
  input  logic [31:0]              halt_tags,
  input  logic                     way_viv,
  input  logic [19:0]              way_main_tag,
  input  logic [255:0]             way_data,
  output logic                     mem_rd_req,
  output logic [ADDR_W-1:0]        mem_rd_addr,
  input  logic                     mem_rd_ack,
  input  logic [255:0]             mem_rd_data,
  output logic [15:0]              hit_count,
  output logic [15:0]              miss_count
);
  localparam int NUM_SETS = 1 << SET_BITS;
  localparam int LINE_W   = ADDR_W - OFFSET_BITS;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_SELECT, S_COMPARE, S_MISS, S_FILL, S_RESP
  } state_t;

  state_t                     state_q, state_d;
  logic [LINE_W-1:0]          addr_q, addr_d;
  logic [7:0]                 cand_q, cand_d;
  logic [255:0]               data_q, data_d;
  logic [255:0]               line_q, line_d;
  logic [23:0]                tag_q, tag_d;
  logic                       hit_q, hit_d;
  logic [NUM_SETS-1:0][2:0]   ptr_q, ptr_d;

  logic [SET_BITS-1:0]        set_idx;
  logic [23:0]                req_tag;
  logic [7:0]                 halt_match;
  logic [7:0]                 first_cand;
  logic [7:0]                 cand_rest;

  assign set_idx    = addr_q[SET_BITS-1:0];
  assign req_tag    = addr_q[LINE_W-1:SET_BITS];
  assign first_cand = cand_q & (~cand_q + 8'd1);
  assign cand_rest  = cand_q & ~first_cand;

  always_comb begin
    halt_match = '0;
    for (int i = 0; i < 8; i++) begin
      halt_match[i] = (halt_tags[4*i +: 4] == req_tag[3:0]);
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cand_d      = cand_q;
    data_d      = data_q;
    line_d      = line_q;
    tag_d       = tag_q;
    hit_d       = hit_q;
    ptr_d       = ptr_q;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    set_out     = NUM_SETS'(1) << set_idx;
    way_sel     = '0;
    mem_write   = 1'b0;
    viv_out     = 1'b0;
    mem_rd_req  = 1'b0;
    mem_rd_addr = '0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        set_out   = '0;
        if (req_valid) begin
          addr_d  = req_addr[ADDR_W-1:OFFSET_BITS];
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        cand_d  = halt_match;
        state_d = (halt_match != '0) ? S_SELECT : S_MISS;
      end
      S_SELECT: begin
        way_sel = first_cand;
        state_d = S_COMPARE;
      end
      S_COMPARE: begin
        way_sel = first_cand;
        if (way_viv && (way_main_tag == req_tag[23:4])) begin
          data_d  = way_data;
          hit_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cand_d  = cand_rest;
          state_d = (cand_rest != '0) ? S_SELECT : S_MISS;
        end
      end
      S_MISS: begin
        mem_rd_req  = 1'b1;
        mem_rd_addr = {addr_q, {OFFSET_BITS{1'b0}}};
        if (mem_rd_ack) begin
          data_d  = mem_rd_data;
          line_d  = mem_rd_data;
          tag_d   = req_tag;
          hit_d   = 1'b0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        // Victim is purely round-robin; way validity is deliberately not consulted.
        way_sel          = 8'b1 << ptr_q[set_idx];
        mem_write        = 1'b1;
        viv_out          = 1'b1;
        ptr_d[set_idx]   = ptr_q[set_idx] + 3'd1;
        state_d          = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cand_q  <= '0;
      data_q  <= '0;
      line_q  <= '0;
      tag_q   <= '0;
      hit_q   <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cand_q  <= cand_d;
      data_q  <= data_d;
      line_q  <= line_d;
      tag_q   <= tag_d;
      hit_q   <= hit_d;
      ptr_q   <= ptr_d;
    end
  end

  assign resp_hit  = hit_q;
  assign resp_data = data_q;
  assign tag_out   = tag_q;
  assign line_out  = line_q;
  assign hit       = 1'b0;

`ifdef CACHE_CTRL_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == S_RESP) begin
      if (hit_q && hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
      if (!hit_q && miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif
endmodule
